inst_fetch_ctrl: RTL and testbench

//  Fetch-stage controller between the PC register and the instruction SRAM-like bus.

---
 rtl/inst_fetch_ctrl_pkg.sv | 25 ++
 rtl/inst_fetch_ctrl_if.sv | 34 +++
 rtl/inst_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_ctrl_pkg
//   Shared definitions for the fetch-stage controller:
//     fetch_state_e  - FSM state encoding (3 bits)
//     RESET_PC       - PC value the core starts fetching from after reset
//     NOP            - instruction word driven on instrF when nothing valid
//     is_misaligned  - word-alignment check on the two low PC bits
package inst_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_FULL    = 3'd3,
        S_DRAIN_A = 3'd4,
        S_DRAIN_D = 3'd5
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [1:0] pc_low);
        return pc_low != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// inst_fetch_ctrl_if
//   SRAM-like instruction read bus (one outstanding transaction).
//   Signals:
//     inst_req      master->slave  read request, held until inst_addr_ok
//     inst_addr     master->slave  request address
//     inst_addr_ok  slave->master  request accepted
//     inst_data_ok  slave->master  read data valid
//     inst_rdata    slave->master  read data
//   Modports: master (fetch controller), slave (memory side).
interface inst_fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             inst_req;
    logic [WIDTH-1:0] inst_addr;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic [WIDTH-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
//   Fetch-stage controller between the PC register and the instruction bus.
//   Issues one read per PC, hands the instruction to decode, and holds the
//   PC (stallF) while a fetch is in flight or decode is stalled. A redirect
//   (flushF) drains and discards whatever transaction is outstanding.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     pcF, ceF      current PC and PC-register valid
//     flushF        redirect: drop the current fetch
//     stallD        decode cannot accept instrF this cycle
//     bus           instruction read bus (master side)
//     instrF        fetched instruction (NOP when not valid)
//     instr_validF  instrF valid this cycle
//     adelF         address error: pcF not word aligned
//     stallF        hold the PC register
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         pcF,
    input  logic                     ceF,
    input  logic                     flushF,
    input  logic                     stallD,
    inst_fetch_ctrl_if.master        bus,
    output logic [WIDTH-1:0]         instrF,
    output logic                     instr_validF,
    output logic                     adelF,
    output logic                     stallF
);

    fetch_state_e     state_reg, state_next;
    logic [WIDTH-1:0] addr_q_reg, addr_q_next;
    logic [WIDTH-1:0] buffer_reg, buffer_next;
    logic             misaligned;

    assign misaligned = is_misaligned(pcF[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            addr_q_reg <= '0;
            buffer_reg <= '0;
        end else begin
            state_reg  <= state_next;
            addr_q_reg <= addr_q_next;
            buffer_reg <= buffer_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_q_next   = addr_q_reg;
        buffer_next   = buffer_reg;
        bus.inst_req  = 1'b0;
        bus.inst_addr = addr_q_reg;
        instrF        = WIDTH'(NOP);
        instr_validF  = 1'b0;
        adelF         = 1'b0;
        stallF        = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (ceF) state_next = S_REQ;
            end

            S_REQ: begin
                // addr_q tracks the PC presented so a redirected request
                // can keep its original address until it is accepted.
                addr_q_next = pcF;
                if (misaligned) begin
                    // Address error completes locally; no bus request.
                    if (!flushF) begin
                        instr_validF = 1'b1;
                        adelF        = 1'b1;
                        stallF       = stallD;
                    end
                end else begin
                    bus.inst_req  = 1'b1;
                    bus.inst_addr = pcF;
                    stallF        = !flushF;
                    if (bus.inst_addr_ok)
                        state_next = flushF ? S_DRAIN_D : S_WAIT;
                    else if (flushF)
                        state_next = S_DRAIN_A;
                end
            end

            S_WAIT: begin
                if (flushF) begin
                    state_next = bus.inst_data_ok ? S_REQ : S_DRAIN_D;
                end else if (bus.inst_data_ok && !stallD) begin
                    instrF       = bus.inst_rdata;
                    instr_validF = 1'b1;
                    state_next   = S_REQ;
                end else begin
                    stallF = 1'b1;
                    if (bus.inst_data_ok) begin
                        buffer_next = bus.inst_rdata;
                        state_next  = S_FULL;
                    end
                end
            end

            S_FULL: begin
                if (flushF) begin
                    state_next = S_REQ;
                end else begin
                    instrF       = buffer_reg;
                    instr_validF = 1'b1;
                    stallF       = stallD;
                    if (!stallD) state_next = S_REQ;
                end
            end

            // Drain states ignore a further flush except for releasing the
            // PC that cycle, so the newest redirect target gets loaded.
            S_DRAIN_A: begin
                bus.inst_req  = 1'b1;
                bus.inst_addr = addr_q_reg;
                stallF        = !flushF;
                if (bus.inst_addr_ok) state_next = S_DRAIN_D;
            end

            S_DRAIN_D: begin
                stallF = !flushF;
                if (bus.inst_data_ok) state_next = S_REQ;
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl
//   Directed bench for inst_fetch_ctrl: normal fetch, decode stall into the
//   buffer, redirect in WAIT and in REQ, misaligned PC, reset mid-fetch.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        ceF;
    logic        flushF;
    logic        stallD;
    logic [31:0] instrF;
    logic        instr_validF;
    logic        adelF;
    logic        stallF;

    int checks   = 0;
    int failures = 0;

    inst_fetch_ctrl_if #(.WIDTH(32)) bus ();

    inst_fetch_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pcF          (pcF),
        .ceF          (ceF),
        .flushF       (flushF),
        .stallD       (stallD),
        .bus          (bus),
        .instrF       (instrF),
        .instr_validF (instr_validF),
        .adelF        (adelF),
        .stallF       (stallF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check every output of the controller at once.
    task automatic expect_all(input string tag, input logic req, input logic [31:0] addr,
                              input logic [31:0] instr, input logic valid,
                              input logic adel, input logic stall);
        chk({tag, ".inst_req"}, {31'd0, bus.inst_req}, {31'd0, req});
        chk({tag, ".inst_addr"}, bus.inst_addr, addr);
        chk({tag, ".instrF"}, instrF, instr);
        chk({tag, ".instr_validF"}, {31'd0, instr_validF}, {31'd0, valid});
        chk({tag, ".adelF"}, {31'd0, adelF}, {31'd0, adel});
        chk({tag, ".stallF"}, {31'd0, stallF}, {31'd0, stall});
        $display("step %s: req=%b addr=%h instr=%h valid=%b adel=%b stall=%b",
                 tag, bus.inst_req, bus.inst_addr, instrF, instr_validF, adelF, stallF);
    endtask

    task automatic drive(input logic [31:0] pc, input logic fl, input logic sd,
                         input logic aok, input logic dok, input logic [31:0] rd);
        pcF              = pc;
        flushF           = fl;
        stallD           = sd;
        bus.inst_addr_ok = aok;
        bus.inst_data_ok = dok;
        bus.inst_rdata   = rd;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ceF = 1'b0;
        drive(32'h0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", 0, 32'h0, 32'h0, 0, 0, 0);

        // 1: plain fetch, addr_ok in cycle 1, data_ok in cycle 2
        rst = 1'b0;
        ceF = 1'b1;
        drive(RESET_PC, 0, 0, 0, 0, 32'h0);
        expect_all("t1.idle", 0, 32'h0, 32'h0, 0, 0, 0);
        next_cycle();
        drive(RESET_PC, 0, 0, 0, 0, 32'h0);
        expect_all("t1.cyc0", 1, RESET_PC, 32'h0, 0, 0, 1);
        next_cycle();
        drive(RESET_PC, 0, 0, 1, 0, 32'h0);
        expect_all("t1.cyc1", 1, RESET_PC, 32'h0, 0, 0, 1);
        next_cycle();
        drive(RESET_PC, 0, 0, 0, 1, 32'h2408_0001);
        expect_all("t1.cyc2", 0, RESET_PC, 32'h2408_0001, 1, 0, 0);
        next_cycle();

        // 2: decode stalls when data arrives; instruction parked in buffer
        drive(32'hbfc0_0004, 0, 0, 1, 0, 32'h0);
        expect_all("t2.req", 1, 32'hbfc0_0004, 32'h0, 0, 0, 1);
        next_cycle();
        drive(32'hbfc0_0004, 0, 1, 0, 1, 32'h2408_0002);
        chk("t2.dok.stallF", {31'd0, stallF}, 32'd1);
        chk("t2.dok.inst_req", {31'd0, bus.inst_req}, 32'd0);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(32'hbfc0_0004, 0, 1, 0, 0, 32'h0);
            expect_all($sformatf("t2.full%0d", i), 0, 32'hbfc0_0004, 32'h2408_0002, 1, 0, 1);
            next_cycle();
        end
        drive(32'hbfc0_0004, 0, 0, 0, 0, 32'h0);
        expect_all("t2.release", 0, 32'hbfc0_0004, 32'h2408_0002, 1, 0, 0);
        next_cycle();
        drive(32'hbfc0_0008, 0, 0, 1, 0, 32'h0);
        expect_all("t2.nextreq", 1, 32'hbfc0_0008, 32'h0, 0, 0, 1);
        next_cycle();

        // 3: redirect while waiting for data; late data is dropped
        drive(32'hbfc0_0008, 1, 0, 0, 0, 32'h0);
        expect_all("t3.flush", 0, 32'hbfc0_0008, 32'h0, 0, 0, 0);
        next_cycle();
        drive(32'hbfc0_0200, 0, 0, 0, 0, 32'h0);
        expect_all("t3.drain0", 0, 32'hbfc0_0008, 32'h0, 0, 0, 1);
        next_cycle();
        drive(32'hbfc0_0200, 0, 0, 0, 1, 32'hdead_beef);
        expect_all("t3.dropped", 0, 32'hbfc0_0008, 32'h0, 0, 0, 1);
        next_cycle();
        drive(32'hbfc0_0200, 0, 0, 0, 0, 32'h0);
        expect_all("t3.newreq", 1, 32'hbfc0_0200, 32'h0, 0, 0, 1);

        // 4: redirect while request not yet accepted
        drive(32'hbfc0_0200, 1, 0, 0, 0, 32'h0);
        expect_all("t4.flush", 1, 32'hbfc0_0200, 32'h0, 0, 0, 0);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(32'hbfc0_0100, 0, 0, 0, 0, 32'h0);
            expect_all($sformatf("t4.draina%0d", i), 1, 32'hbfc0_0200, 32'h0, 0, 0, 1);
            next_cycle();
        end
        drive(32'hbfc0_0100, 0, 0, 1, 0, 32'h0);
        expect_all("t4.aok", 1, 32'hbfc0_0200, 32'h0, 0, 0, 1);
        next_cycle();
        drive(32'hbfc0_0100, 1, 1, 0, 0, 32'h0);
        expect_all("t4.draind.flush", 0, 32'hbfc0_0200, 32'h0, 0, 0, 0);
        next_cycle();
        drive(32'hbfc0_0100, 0, 0, 0, 1, 32'h1111_1111);
        expect_all("t4.dropped", 0, 32'hbfc0_0200, 32'h0, 0, 0, 1);
        next_cycle();
        drive(32'hbfc0_0100, 0, 0, 1, 0, 32'h0);
        expect_all("t4.newreq", 1, 32'hbfc0_0100, 32'h0, 0, 0, 1);
        next_cycle();
        drive(32'hbfc0_0100, 0, 0, 0, 1, 32'h3c1d_0001);
        expect_all("t4.data", 0, 32'hbfc0_0100, 32'h3c1d_0001, 1, 0, 0);
        next_cycle();

        // 5: misaligned PC completes locally with an address error
        drive(32'hbfc0_0002, 0, 0, 0, 0, 32'h0);
        expect_all("t5.adel", 0, 32'hbfc0_0100, 32'h0, 1, 1, 0);
        next_cycle();
        drive(32'hbfc0_0002, 0, 1, 0, 0, 32'h0);
        expect_all("t5.adel.stallD", 0, 32'hbfc0_0002, 32'h0, 1, 1, 1);
        next_cycle();
        drive(32'hbfc0_0002, 1, 1, 0, 0, 32'h0);
        expect_all("t5.adel.flush", 0, 32'hbfc0_0002, 32'h0, 0, 0, 0);
        next_cycle();
        drive(32'hbfc0_0010, 0, 0, 1, 0, 32'h0);
        expect_all("t5.aligned", 1, 32'hbfc0_0010, 32'h0, 0, 0, 1);
        next_cycle();

        // 6: reset while waiting for data
        rst = 1'b1;
        drive(32'hbfc0_0010, 0, 0, 0, 0, 32'h0);
        next_cycle();
        rst = 1'b0;
        ceF = 1'b0;
        drive(32'hbfc0_0010, 0, 0, 0, 1, 32'h2222_2222);
        expect_all("t6.afterrst", 0, 32'h0, 32'h0, 0, 0, 0);
        next_cycle();
        drive(32'hbfc0_0010, 0, 0, 0, 0, 32'h0);
        expect_all("t6.idle.noce", 0, 32'h0, 32'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
